composite_sync_decoder: RTL and testbench

- Receiver counterpart of the composite video generator. It samples the two-level composite pair (video level and active-low sync tip) and separates horizontal and vertical sync by measuring pulse widths.
- It recovers line and pixel timing, then emits a line counter, a pixel position and a qualified video sample stream for downstream capture and debug logic.
- It runs on the same internal-oscillator-derived clock domain as the generator (12 MHz nominal).

---
 rtl/composite_sync_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_composite_sync_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/composite_sync_decoder.sv
// Composite sync decoder: classifies sync-tip widths into equalizing, hsync and broad
// pulses, declares vsync/lock, and recovers line, pixel position and active video.
module composite_sync_decoder #(
  parameter int unsigned EQ_MIN     = 20,
  parameter int unsigned HS_MIN     = 40,
  parameter int unsigned HS_MAX     = 80,
  parameter int unsigned BROAD_MIN  = 200,
  parameter int unsigned VS_BROADS  = 3,
  parameter int unsigned BACK_PORCH = 68,
  parameter int unsigned ACTIVE     = 624,
  parameter int unsigned TIMEOUT    = 1536
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sync_in_n,
  input  logic       i_vid_in,
  output logic       o_hsync_stb,
  output logic       o_vsync_stb,
  output logic       o_locked,
  output logic [9:0] o_line,
  output logic [9:0] o_xpos,
  output logic       o_pix_valid,
  output logic       o_pix
);

  localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);
  localparam int unsigned BrW    = $clog2(VS_BROADS + 1);
  localparam int unsigned PorchW = $clog2(BACK_PORCH + 1);

  localparam logic [8:0] WidthMax  = 9'd511;
  localparam logic [8:0] EqMinW    = 9'(EQ_MIN);
  localparam logic [8:0] HsMinW    = 9'(HS_MIN);
  localparam logic [8:0] HsMaxW    = 9'(HS_MAX);
  localparam logic [8:0] BroadMinW = 9'(BROAD_MIN);

  typedef enum logic [1:0] {
    StIdle,
    StPorch,
    StActive,
    StBlank
  } state_e;

  logic              r_sync_meta;
  logic              r_sync;
  logic              r_sync_prev;
  logic              r_vid_meta;
  logic              r_vid;
  logic [8:0]        r_width;
  logic [TmoW-1:0]   r_tmo;
  logic [BrW-1:0]    r_broads;
  logic [PorchW-1:0] r_porch;
  logic              r_hsync_stb;
  logic              r_vsync_stb;
  logic              r_locked;
  logic [9:0]        r_line;
  logic [9:0]        r_xpos;
  logic              r_pix_valid;
  logic              r_pix;
  state_e            r_state;

  logic w_fall;
  logic w_rise;
  logic w_is_eq;
  logic w_is_hs;
  logic w_is_broad;
  logic w_event;
  logic w_timeout;
  logic w_vsync;

  assign w_fall     = r_sync_prev & ~r_sync;
  assign w_rise     = ~r_sync_prev & r_sync;
  assign w_is_eq    = w_rise & (r_width >= EqMinW) & (r_width < HsMinW);
  assign w_is_hs    = w_rise & (r_width >= HsMinW) & (r_width <= HsMaxW);
  assign w_is_broad = w_rise & (r_width >= BroadMinW);
  assign w_event    = w_is_eq | w_is_hs | w_is_broad;
  assign w_timeout  = ~w_event & (r_tmo == TmoW'(TIMEOUT - 1));
  assign w_vsync    = w_is_broad & (r_broads == BrW'(VS_BROADS - 1));

  // Input synchronizers, sync-low width measurement and the quiet-time counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync_meta <= 1'b1;
      r_sync      <= 1'b1;
      r_sync_prev <= 1'b1;
      r_vid_meta  <= 1'b0;
      r_vid       <= 1'b0;
      r_width     <= '0;
      r_tmo       <= '0;
    end else begin
      r_sync_meta <= i_sync_in_n;
      r_sync      <= r_sync_meta;
      r_sync_prev <= r_sync;
      r_vid_meta  <= i_vid_in;
      r_vid       <= r_vid_meta;
      if (!r_sync) begin
        if (w_fall) begin
          r_width <= 9'd1;
        end else if (r_width != WidthMax) begin
          r_width <= r_width + 9'd1;
        end
      end
      // Holds at TIMEOUT so the drop-lock action fires only once per quiet spell.
      if (w_event) begin
        r_tmo <= '0;
      end else if (r_tmo != TmoW'(TIMEOUT)) begin
        r_tmo <= r_tmo + TmoW'(1);
      end
    end
  end

  // Sync classification results: strobes, broad-pulse run, lock and line number.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hsync_stb <= 1'b0;
      r_vsync_stb <= 1'b0;
      r_locked    <= 1'b0;
      r_line      <= '0;
      r_broads    <= '0;
    end else begin
      r_hsync_stb <= w_is_hs;
      r_vsync_stb <= w_vsync;
      if (w_timeout) begin
        r_locked <= 1'b0;
        r_line   <= '0;
        r_broads <= '0;
      end else if (w_is_eq) begin
        r_broads <= '0;
      end else if (w_is_hs) begin
        r_broads <= '0;
        if (r_locked && (r_line != 10'd1023)) begin
          r_line <= r_line + 10'd1;
        end
      end else if (w_is_broad) begin
        if (w_vsync) begin
          r_broads <= '0;
          r_line   <= '0;
          r_locked <= 1'b1;
        end else begin
          r_broads <= r_broads + BrW'(1);
        end
      end
    end
  end

  // Line FSM with registered pixel qualifier, position and sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_porch     <= '0;
      r_xpos      <= '0;
      r_pix_valid <= 1'b0;
      r_pix       <= 1'b0;
    end else if (w_timeout) begin
      r_state     <= StIdle;
      r_pix_valid <= 1'b0;
    end else if (w_is_hs) begin
      r_state     <= StPorch;
      r_porch     <= '0;
      r_pix_valid <= 1'b0;
    end else if (w_fall && ((r_state == StPorch) || (r_state == StActive))) begin
      r_state     <= StBlank;
      r_pix_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StBlank: begin
          r_state <= r_state;
        end
        StPorch: begin
          if (r_porch == PorchW'(BACK_PORCH - 1)) begin
            r_state     <= StActive;
            r_pix_valid <= 1'b1;
            r_xpos      <= '0;
            r_pix       <= r_vid;
          end else begin
            r_porch <= r_porch + PorchW'(1);
          end
        end
        StActive: begin
          if (r_xpos == 10'(ACTIVE - 1)) begin
            r_state     <= StBlank;
            r_pix_valid <= 1'b0;
          end else begin
            r_xpos <= r_xpos + 10'd1;
            r_pix  <= r_vid;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_hsync_stb = r_hsync_stb;
  assign o_vsync_stb = r_vsync_stb;
  assign o_locked    = r_locked;
  assign o_line      = r_line;
  assign o_xpos      = r_xpos;
  assign o_pix_valid = r_pix_valid;
  assign o_pix       = r_pix;

endmodule

// File: tb/tb_composite_sync_decoder.sv
// Randomized bench for composite_sync_decoder against a timestamp-based reference model
// that classifies pulses by width and places the pixel window relative to each hsync.
module tb_composite_sync_decoder;

  localparam int EQ_MIN     = 20;
  localparam int HS_MIN     = 40;
  localparam int HS_MAX     = 80;
  localparam int BROAD_MIN  = 200;
  localparam int VS_BROADS  = 3;
  localparam int BACK_PORCH = 68;
  localparam int ACTIVE     = 624;
  localparam int TIMEOUT    = 1536;

  logic       clk;
  logic       i_rst;
  logic       i_sync_in_n;
  logic       i_vid_in;
  logic       o_hsync_stb;
  logic       o_vsync_stb;
  logic       o_locked;
  logic [9:0] o_line;
  logic [9:0] o_xpos;
  logic       o_pix_valid;
  logic       o_pix;

  composite_sync_decoder u_dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_sync_in_n (i_sync_in_n),
    .i_vid_in    (i_vid_in),
    .o_hsync_stb (o_hsync_stb),
    .o_vsync_stb (o_vsync_stb),
    .o_locked    (o_locked),
    .o_line      (o_line),
    .o_xpos      (o_xpos),
    .o_pix_valid (o_pix_valid),
    .o_pix       (o_pix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state; expectations refer to the outputs after the next edge.
  bit m_sprev;
  int m_low;
  int m_broads;
  bit m_locked;
  int m_line;
  int m_last_evt;
  int m_hs_at;
  bit m_win;
  int m_xpos;
  bit e_hs;
  bit e_vs;
  bit e_pv;
  bit e_pix;
  bit in_d1;
  bit v_d1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: observed 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    m_sprev    = 1'b1;
    m_low      = 0;
    m_broads   = 0;
    m_locked   = 1'b0;
    m_line     = 0;
    m_last_evt = cyc;
    m_hs_at    = -100000;
    m_win      = 1'b0;
    m_xpos     = 0;
    e_hs       = 1'b0;
    e_vs       = 1'b0;
    e_pv       = 1'b0;
    e_pix      = 1'b0;
    in_d1      = 1'b1;
    v_d1       = 1'b0;
  endtask

  // Consumes the synchronized sample seen after edge cyc, predicts outputs after cyc+1.
  task automatic model_step();
    int n1;
    int w;
    int off;
    bit sv;
    bit rise;
    bit fall;
    bit ev_eq;
    bit ev_hs;
    bit ev_br;
    n1    = cyc + 1;
    sv    = in_d1;
    rise  = !m_sprev && sv;
    fall  = m_sprev && !sv;
    w     = m_low;
    ev_eq = rise && (w >= EQ_MIN) && (w < HS_MIN);
    ev_hs = rise && (w >= HS_MIN) && (w <= HS_MAX);
    ev_br = rise && (w >= BROAD_MIN);
    if (!sv) m_low = fall ? 1 : ((m_low < 511) ? m_low + 1 : 511);
    m_sprev = sv;
    e_hs = 1'b0;
    e_vs = 1'b0;
    if (ev_eq || ev_hs || ev_br) begin
      m_last_evt = n1;
    end else if (n1 - m_last_evt == TIMEOUT) begin
      m_locked = 1'b0;
      m_line   = 0;
      m_broads = 0;
      m_win    = 1'b0;
    end
    if (ev_eq) m_broads = 0;
    if (ev_hs) begin
      e_hs     = 1'b1;
      m_broads = 0;
      if (m_locked && m_line < 1023) m_line++;
      m_hs_at  = n1;
      m_win    = 1'b1;
    end
    if (ev_br) begin
      m_broads++;
      if (m_broads == VS_BROADS) begin
        e_vs     = 1'b1;
        m_line   = 0;
        m_locked = 1'b1;
        m_broads = 0;
      end
    end
    if (fall) m_win = 1'b0;
    off  = n1 - m_hs_at - BACK_PORCH;
    e_pv = m_win && (off >= 0) && (off < ACTIVE);
    if (e_pv) begin
      m_xpos = off;
      e_pix  = v_d1;
    end
  endtask

  task automatic tick(input logic s, input logic v);
    i_sync_in_n = s;
    i_vid_in    = v;
    @(posedge clk);
    #1;
    cyc++;
    check("sync", 32'({o_hsync_stb, o_vsync_stb, o_locked, o_line}),
          32'({e_hs, e_vs, m_locked, 10'(m_line)}));
    check("pix", 32'({o_pix_valid, o_xpos, e_pv ? o_pix : 1'b0}),
          32'({e_pv, 10'(m_xpos), e_pv ? e_pix : 1'b0}));
    if (i_rst) begin
      model_reset();
    end else begin
      model_step();
      in_d1 = s;
      v_d1  = v;
    end
  endtask

  task automatic pulse(input int low, input int high);
    for (int i = 0; i < low; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < high; i++) tick(1'b1, 1'($urandom_range(0, 1)));
  endtask

  int widths[13] = '{10, 20, 30, 39, 40, 56, 80, 81, 120, 200, 300, 511, 600};

  initial begin
    i_rst       = 1'b1;
    i_sync_in_n = 1'b1;
    i_vid_in    = 1'b0;
    model_reset();
    repeat (3) tick(1'b1, 1'b0);
    i_rst = 1'b0;

    // Acquire vsync, then several full lines.
    repeat (3) pulse(300, 84);
    repeat (4) pulse(56, 712);

    // Overlong pulse and short glitch, each landing inside active video.
    pulse(56, 200);
    pulse(120, 300);
    pulse(56, 200);
    pulse(10, 300);
    pulse(56, 712);

    // Broad run broken by an equalizing pulse.
    repeat (2) pulse(300, 84);
    pulse(30, 84);
    repeat (4) pulse(300, 84);
    pulse(56, 712);

    // Quiet line long enough to drop lock, then an unlocked hsync.
    pulse(56, 1700);
    pulse(56, 712);

    // Width boundaries.
    pulse(40, 300);
    pulse(80, 300);
    pulse(39, 300);
    pulse(81, 300);
    pulse(300, 84);
    pulse(39, 84);
    repeat (3) pulse(200, 100);
    pulse(56, 712);

    // Asynchronous reset while active video is flowing.
    pulse(56, 200);
    #2 i_rst = 1'b1;
    #1;
    check("rst_async", 32'({o_hsync_stb, o_vsync_stb, o_locked, o_line, o_xpos, o_pix_valid,
                            o_pix}), 32'd0);
    model_reset();
    repeat (2) tick(1'b1, 1'b0);
    i_rst = 1'b0;
    pulse(0, 400);
    repeat (3) pulse(300, 84);
    repeat (2) pulse(56, 712);

    // Random pulse mix.
    for (int k = 0; k < 20; k++) begin
      pulse(widths[$urandom_range(0, 12)], $urandom_range(100, 800));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
